// File: rtl/csa_pkg.sv
// csa_pkg: shared constants and types for the CSA transmit-side packet buffer.
//   TS_WORDS_PER_PKT : 33-bit words per transport-stream packet
//   TS_WORD_W        : width of one stream word (SOP flag + four TS bytes)
//   TS_SOP_BIT       : bit position of the start-of-packet flag
//   wr_state_e       : write-side FSM encoding
//   sat_inc16        : 16-bit saturating increment for drop statistics
package csa_pkg;

  localparam int TS_WORDS_PER_PKT = 47;
  localparam int TS_WORD_W        = 33;
  localparam int TS_SOP_BIT       = 32;
  localparam int SLOT_IDX_W       = 6;
  localparam logic [SLOT_IDX_W-1:0] LAST_WORD_IDX = SLOT_IDX_W'(TS_WORDS_PER_PKT - 1);

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_FILL    = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/csa_pkt_buf_if.sv
// csa_pkt_buf_if: stream bundle around the packet buffer.
//   ts_din_en / ts_din     : scrambler word stream into the buffer (no ready)
//   ts_dout_rdy            : downstream ready
//   ts_dout_en / ts_dout   : packet stream out of the buffer
// slave modport is the buffer's view; master is the surrounding environment.
interface csa_pkt_buf_if;
  import csa_pkg::*;

  logic                 ts_din_en;
  logic [TS_WORD_W-1:0] ts_din;
  logic                 ts_dout_rdy;
  logic                 ts_dout_en;
  logic [TS_WORD_W-1:0] ts_dout;

  modport slave (
    input  ts_din_en, ts_din, ts_dout_rdy,
    output ts_dout_en, ts_dout
  );

  modport master (
    output ts_din_en, ts_din, ts_dout_rdy,
    input  ts_dout_en, ts_dout
  );

endinterface

// File: rtl/csa_pkt_ram.sv
// csa_pkt_ram: simple dual-port packet store, DEPTH_PKTS slots of 64 words.
//   clk   : clock (rising edge)
//   we    : write enable, waddr/wdata written at the edge
//   re    : read enable; rdata is registered and holds while re is low
//   raddr : read address {slot, word}
// No reset: contents are don't-care until a packet is committed over them.
module csa_pkt_ram
  import csa_pkg::*;
#(
  parameter int DEPTH_PKTS = 4
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [$clog2(DEPTH_PKTS)+5:0]       waddr,
  input  logic [TS_WORD_W-1:0]                wdata,
  input  logic                                re,
  input  logic [$clog2(DEPTH_PKTS)+5:0]       raddr,
  output logic [TS_WORD_W-1:0]                rdata
);

  logic [TS_WORD_W-1:0] mem [0:DEPTH_PKTS*64-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/csa_pkt_buf.sv
// csa_pkt_buf: packet-granular output buffer behind the CSA scrambler.
// Stores only complete 47-word packets and replays them under valid/ready.
//   clk_main     : system clock
//   rst          : synchronous, active-high reset
//   ts           : csa_pkt_buf_if.slave (input stream, output stream, ready)
//   pkt_level    : committed packets currently held
//   drop_ovf_cnt : packets dropped for lack of a free slot   (CSA_PKT_BUF_STAT_EN)
//   drop_err_cnt : packets dropped as malformed               (CSA_PKT_BUF_STAT_EN)
// Build option: define CSA_PKT_BUF_STAT_EN to add the two drop counters.
//
// Write FSM
//   state      | meaning
//   WR_IDLE    | between packets, waiting for SOP
//   WR_FILL    | storing words 1..46 of the current packet into wr_slot
//   WR_DISCARD | packet rejected (buffer full), ignoring words until next SOP
module csa_pkt_buf
  import csa_pkg::*;
#(
  parameter int DEPTH_PKTS = 4
) (
  input  logic              clk_main,
  input  logic              rst,
  csa_pkt_buf_if.slave      ts,
  output logic [4:0]        pkt_level
`ifdef CSA_PKT_BUF_STAT_EN
  ,
  output logic [15:0]       drop_ovf_cnt,
  output logic [15:0]       drop_err_cnt
`endif
);

  localparam int SLOT_W = $clog2(DEPTH_PKTS);
  localparam int AW     = SLOT_W + SLOT_IDX_W;
  localparam logic [4:0] DEPTH_LVL = 5'(DEPTH_PKTS);

  // write side
  wr_state_e             wr_state, wr_state_n;
  logic [SLOT_W-1:0]     wr_slot, wr_slot_n;
  logic [SLOT_IDX_W-1:0] wr_idx, wr_idx_n, wr_idx_inc;
  logic                  err_armed, err_armed_n;
  logic                  ram_we;
  logic [AW-1:0]         ram_waddr;
  logic                  commit, ovf_hit, err_hit;
  logic                  din_sop;

  // read side
  logic [SLOT_W-1:0]     iss_slot;
  logic [SLOT_IDX_W-1:0] iss_word;
  logic                  iss_ahead;
  logic                  iss_last, iss_ok, issue;
  logic                  s1_v, s1_last, out_last;
  logic                  out_ld, s1_free, release_pkt;
  logic [TS_WORD_W-1:0]  ram_rdata;

  assign din_sop    = ts.ts_din[TS_SOP_BIT];
  assign wr_idx_inc = wr_idx + SLOT_IDX_W'(1);

  always_ff @(posedge clk_main) begin
    if (rst) begin
      wr_state  <= WR_IDLE;
      wr_slot   <= '0;
      wr_idx    <= '0;
      err_armed <= 1'b1;
    end else begin
      wr_state  <= wr_state_n;
      wr_slot   <= wr_slot_n;
      wr_idx    <= wr_idx_n;
      err_armed <= err_armed_n;
    end
  end

  always_comb begin
    wr_state_n  = wr_state;
    wr_slot_n   = wr_slot;
    wr_idx_n    = wr_idx;
    err_armed_n = err_armed;
    ram_we      = 1'b0;
    ram_waddr   = {wr_slot, wr_idx_inc};
    commit      = 1'b0;
    ovf_hit     = 1'b0;
    err_hit     = 1'b0;
    if (ts.ts_din_en) begin
      if (din_sop) begin
        // An SOP always restarts; a packet in progress is abandoned and its
        // slot reused, since wr_slot only advances on commit.
        if (wr_state == WR_FILL) err_hit = 1'b1;
        if (pkt_level < DEPTH_LVL) begin
          ram_we     = 1'b1;
          ram_waddr  = {wr_slot, {SLOT_IDX_W{1'b0}}};
          wr_idx_n   = '0;
          wr_state_n = WR_FILL;
        end else begin
          ovf_hit    = 1'b1;
          wr_state_n = WR_DISCARD;
        end
      end else begin
        unique case (wr_state)
          WR_FILL: begin
            ram_we   = 1'b1;
            wr_idx_n = wr_idx_inc;
            if (wr_idx_inc == LAST_WORD_IDX) begin
              commit      = 1'b1;
              wr_slot_n   = wr_slot + SLOT_W'(1);
              wr_state_n  = WR_IDLE;
              err_armed_n = 1'b1;
            end
          end
          WR_IDLE: begin
            // only the first stray word after a packet boundary is counted
            if (err_armed) begin
              err_hit     = 1'b1;
              err_armed_n = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read pipeline: issue -> RAM output register (s1) -> output register.
  // The RAM holds its output while not re-enabled, so s1 needs no extra copy.
  assign out_ld      = !ts.ts_dout_en || ts.ts_dout_rdy;
  assign s1_free     = !s1_v || out_ld;
  assign iss_last    = (iss_word == LAST_WORD_IDX);
  // iss_ahead marks a packet fully issued but not yet released, so it must
  // not be counted again as available for issue.
  assign iss_ok      = (pkt_level > {4'd0, iss_ahead});
  assign issue       = iss_ok && s1_free;
  assign release_pkt = ts.ts_dout_en && ts.ts_dout_rdy && out_last;

  csa_pkt_ram #(.DEPTH_PKTS(DEPTH_PKTS)) u_ram (
    .clk   (clk_main),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ts.ts_din),
    .re    (issue),
    .raddr ({iss_slot, iss_word}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_main) begin
    if (rst) begin
      iss_slot      <= '0;
      iss_word      <= '0;
      iss_ahead     <= 1'b0;
      s1_v          <= 1'b0;
      s1_last       <= 1'b0;
      out_last      <= 1'b0;
      ts.ts_dout_en <= 1'b0;
      ts.ts_dout    <= '0;
    end else begin
      if (issue) begin
        iss_word <= iss_last ? '0 : iss_word + SLOT_IDX_W'(1);
        if (iss_last) iss_slot <= iss_slot + SLOT_W'(1);
      end

      if (issue && iss_last)  iss_ahead <= 1'b1;
      else if (release_pkt)   iss_ahead <= 1'b0;

      if (issue) begin
        s1_v    <= 1'b1;
        s1_last <= iss_last;
      end else if (out_ld) begin
        s1_v    <= 1'b0;
      end

      if (out_ld) begin
        ts.ts_dout_en <= s1_v;
        if (s1_v) begin
          ts.ts_dout <= ram_rdata;
          out_last   <= s1_last;
        end
      end
    end
  end

  always_ff @(posedge clk_main) begin
    if (rst) begin
      pkt_level <= '0;
    end else begin
      unique case ({commit, release_pkt})
        2'b10:   pkt_level <= pkt_level + 5'd1;
        2'b01:   pkt_level <= pkt_level - 5'd1;
        default: pkt_level <= pkt_level;
      endcase
    end
  end

`ifdef CSA_PKT_BUF_STAT_EN
  always_ff @(posedge clk_main) begin
    if (rst) begin
      drop_ovf_cnt <= '0;
      drop_err_cnt <= '0;
    end else begin
      if (ovf_hit) drop_ovf_cnt <= sat_inc16(drop_ovf_cnt);
      if (err_hit) drop_err_cnt <= sat_inc16(drop_err_cnt);
    end
  end
`else
  logic stat_unused;
  assign stat_unused = ovf_hit ^ err_hit;
`endif

endmodule

// File: tb/tb_csa_pkt_buf.sv
// tb_csa_pkt_buf: directed, table-driven bench for csa_pkt_buf (DEPTH_PKTS=4).
module tb_csa_pkt_buf;
  import csa_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = TS_WORDS_PER_PKT;

  logic       clk_main = 1'b0;
  logic       rst;
  logic [4:0] pkt_level;
`ifdef CSA_PKT_BUF_STAT_EN
  logic [15:0] drop_ovf_cnt;
  logic [15:0] drop_err_cnt;
`endif

  csa_pkt_buf_if bus();

  csa_pkt_buf #(.DEPTH_PKTS(DEPTH)) dut (
    .clk_main  (clk_main),
    .rst       (rst),
    .ts        (bus),
    .pkt_level (pkt_level)
`ifdef CSA_PKT_BUF_STAT_EN
    ,
    .drop_ovf_cnt (drop_ovf_cnt),
    .drop_err_cnt (drop_err_cnt)
`endif
  );

  always #5 clk_main = ~clk_main;

  int cyc = 0;
  always @(posedge clk_main) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 0;  // 0: low, 1: high, 2: toggle every cycle

  typedef struct {
    logic [32:0] w;
    int          c;
  } xfer_t;
  xfer_t got[$];

  typedef struct {
    int abort_at;   // words of a truncated packet sent first (0 = none)
    int first_id;
    int n_pkts;
    int gap;        // idle cycles between full packets
    int junk;       // stray non-SOP words after the last packet
    int rdy_in;
    int rdy_out;
    int exp_level;  // level right after the last input edge
    int kept_first;
    int kept_n;
    bit contig;
    int exp_ovf;
    int exp_err;
  } vec_t;

  function automatic logic [32:0] pkt_word(input int id, input int i);
    return {(i == 0), 8'(id), 8'hA5 ^ 8'(i), 16'(i * 257 + id)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Output monitor plus stall-hold check, sampled on the falling edge.
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word  = '0;
  always @(negedge clk_main) begin
    if (prev_stall) begin
      n_checks++;
      if (!(bus.ts_dout_en === 1'b1 && bus.ts_dout === prev_word)) begin
        n_fail++;
        $display("FAIL hold: en=%0b dout=%h required en=1 dout=%h",
                 bus.ts_dout_en, bus.ts_dout, prev_word);
      end
    end
    prev_stall = !rst && bus.ts_dout_en && !bus.ts_dout_rdy;
    prev_word  = bus.ts_dout;
    if (!rst && bus.ts_dout_en && bus.ts_dout_rdy)
      got.push_back('{bus.ts_dout, cyc});
  end

  task automatic step();
    @(posedge clk_main);
    #1;
    case (rdy_mode)
      0:       bus.ts_dout_rdy = 1'b0;
      1:       bus.ts_dout_rdy = 1'b1;
      default: bus.ts_dout_rdy = cyc[0];
    endcase
  endtask

  task automatic send(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ts_din_en = 1'b1;
      bus.ts_din    = pkt_word(id, i);
      step();
    end
    bus.ts_din_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ts_din_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic drain_check(input string tag, input int first_id, input int n_pkts, input bit contig);
    int budget;
    int exp_words;
    int nchk;
    budget    = 1500;
    exp_words = n_pkts * PW;
    while (got.size() < exp_words && budget > 0) begin
      step();
      budget--;
    end
    repeat (8) step();
    check({tag, "_count"}, got.size(), exp_words);
    nchk = (got.size() < exp_words) ? got.size() : exp_words;
    for (int k = 0; k < nchk; k++)
      check($sformatf("%s_word%0d", tag, k), got[k].w, pkt_word(first_id + k / PW, k % PW));
    if (contig && got.size() > 0)
      check({tag, "_contig"}, got[got.size()-1].c - got[0].c + 1, exp_words);
    @(negedge clk_main);
    check({tag, "_level_end"}, pkt_level, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{0, 10, 1, 0, 0, 1, 1, 1, 10, 1, 0, 0, 0}; // single packet
    vecs[1] = '{0, 20, 5, 0, 0, 0, 1, 4, 20, 4, 1, 1, 0}; // overflow, 5th dropped
    vecs[2] = '{20, 31, 1, 0, 0, 1, 1, 1, 31, 1, 0, 0, 1}; // SOP at word 20
    vecs[3] = '{0, 40, 2, 0, 0, 1, 1, 2, 40, 2, 1, 0, 0}; // back-to-back, no bubble
    vecs[4] = '{0, 50, 2, 2, 0, 1, 1, 1, 50, 2, 0, 0, 0}; // commit == final read
    vecs[5] = '{0, 60, 2, 0, 0, 2, 2, 2, 60, 2, 0, 0, 0}; // rdy toggling
    vecs[6] = '{0, 70, 1, 0, 5, 1, 1, 1, 70, 1, 0, 0, 1}; // stray words after packet

    rst = 1'b1;
    bus.ts_din_en   = 1'b0;
    bus.ts_din      = '0;
    bus.ts_dout_rdy = 1'b0;

    // reset state
    step();
    step();
    @(negedge clk_main);
    check("rst_dout_en", bus.ts_dout_en, 0);
    check("rst_dout", bus.ts_dout, 0);
    check("rst_level", pkt_level, 0);
`ifdef CSA_PKT_BUF_STAT_EN
    check("rst_ovf", drop_ovf_cnt, 0);
    check("rst_err", drop_err_cnt, 0);
`endif
    rst = 1'b0;

    for (int r = 0; r < 7; r++) begin
      do_reset();
      rdy_mode = vecs[r].rdy_in;
      if (vecs[r].abort_at > 0) send(vecs[r].first_id - 1, vecs[r].abort_at);
      for (int p = 0; p < vecs[r].n_pkts; p++) begin
        send(vecs[r].first_id + p, PW);
        if (p < vecs[r].n_pkts - 1)
          for (int g = 0; g < vecs[r].gap; g++) step();
      end
      for (int j = 0; j < vecs[r].junk; j++) begin
        bus.ts_din_en = 1'b1;
        bus.ts_din    = pkt_word(99, j + 1);
        step();
      end
      bus.ts_din_en = 1'b0;
      @(negedge clk_main);
      check($sformatf("v%0d_level_in", r), pkt_level, vecs[r].exp_level);
      rdy_mode = vecs[r].rdy_out;
      drain_check($sformatf("v%0d", r), vecs[r].kept_first, vecs[r].kept_n, vecs[r].contig);
`ifdef CSA_PKT_BUF_STAT_EN
      check($sformatf("v%0d_ovf", r), drop_ovf_cnt, vecs[r].exp_ovf);
      check($sformatf("v%0d_err", r), drop_err_cnt, vecs[r].exp_err);
`endif
    end

    // first-output latency: valid appears two edges after the commit edge
    do_reset();
    rdy_mode = 1;
    send(5, PW);
    @(negedge clk_main);
    check("lat_en_c0", bus.ts_dout_en, 0);
    check("lat_level_c0", pkt_level, 1);
    step();
    @(negedge clk_main);
    check("lat_en_c1", bus.ts_dout_en, 0);
    step();
    @(negedge clk_main);
    check("lat_en_c2", bus.ts_dout_en, 1);
    check("lat_dout_c2", bus.ts_dout, pkt_word(5, 0));
    drain_check("lat", 5, 1, 1'b1);

    // reset while a packet is streaming out and another is half written
    do_reset();
    rdy_mode = 0;
    send(80, PW);
    rdy_mode = 1;
    send(81, 10);
    rst = 1'b1;
    step();
    @(negedge clk_main);
    check("mid_rst_en", bus.ts_dout_en, 0);
    check("mid_rst_level", pkt_level, 0);
    rst = 1'b0;
    got.delete();
    step();
    send(82, PW);
    drain_check("post_rst", 82, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
